// File: rtl/fp_accum_ctrl.sv
// ----------------------------------------------------------------------------
// fp_accum_ctrl
//   Sequencing controller that sums a stream of IEEE-754 single-precision
//   operands using one shared multi-cycle FP adder.
//
//   The first element of a sum is loaded straight into the accumulator. Each
//   further element is paired with the running accumulator and handed to the
//   adder with a one-cycle start pulse. The controller then waits for finish
//   and captures the result. The final value is offered on a valid/ready
//   output.
//
//   A watchdog bounds the wait for the adder. If the adder does not answer
//   within TIMEOUT cycles, the controller raises a sticky error flag and
//   returns the accumulator as it stood.
//
//   Optional feature macro: FP_ACCUM_ZERO_SKIP_EN
//     When defined, +/-0 operands are counted but never sent to the adder.
//     When the accumulator is +/-0, a nonzero operand is loaded directly
//     instead of being added.
// ----------------------------------------------------------------------------
module fp_accum_ctrl #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [31:0]      add_a,
   output logic [31:0]      add_b,
   output logic             add_start,
   input  logic [31:0]      add_result,
   input  logic             add_finish,
   output logic [31:0]      sum,
   output logic             sum_valid,
   input  logic             sum_ready,
   output logic [CNT_W-1:0] count,
   output logic             timeout_err
);

   localparam int               TMR_W    = $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Element counter that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == CNT_MAX) begin
         r = v;
      end else begin
         r = v + CNT_W'(1);
      end
      return r;
   endfunction

`ifdef FP_ACCUM_ZERO_SKIP_EN
   // True for +0 and -0 (magnitude bits all clear).
   function automatic logic mag_is_zero(input logic [31:0] v);
      return (v[30:0] == 31'd0);
   endfunction
`endif

   state_t             state_q, state_d;
   logic [31:0]        acc_q, acc_d;
   logic [31:0]        opnd_q, opnd_d;
   logic               last_f_q, last_f_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               timeout_err_q, timeout_err_d;
   logic               add_start_q, add_start_d;
   logic [31:0]        add_a_q, add_a_d;
   logic [31:0]        sum_q, sum_d;
   logic               sum_valid_q, sum_valid_d;
   logic               skip_s;
   logic               in_ready_s;
   logic               transfer_s;

   // Input readiness is a pure decode of the state.
   assign in_ready_s = (state_q == S_IDLE) || (state_q == S_FETCH);
   assign transfer_s = in_valid & in_ready_s;

   // Next-state and next-output computation for the sequencing FSM.
   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      opnd_d        = opnd_q;
      last_f_d      = last_f_q;
      timer_d       = timer_q;
      count_d       = count_q;
      timeout_err_d = timeout_err_q;
      add_start_d   = 1'b0;
      add_a_d       = add_a_q;
      sum_d         = sum_q;
      sum_valid_d   = sum_valid_q;
      skip_s        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (transfer_s) begin
               // First element seeds the accumulator; it never visits the adder.
               acc_d         = in_data;
               count_d       = CNT_W'(1);
               timeout_err_d = 1'b0;
               if (in_last) begin
                  state_d     = S_DONE;
                  sum_d       = in_data;
                  sum_valid_d = 1'b1;
               end else begin
                  state_d = S_FETCH;
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_FETCH: begin
            if (transfer_s) begin
               opnd_d   = in_data;
               last_f_d = in_last;
               count_d  = sat_inc(count_q);
`ifdef FP_ACCUM_ZERO_SKIP_EN
               if (mag_is_zero(in_data)) begin
                  skip_s = 1'b1;
               end else if (mag_is_zero(acc_q)) begin
                  skip_s = 1'b1;
                  acc_d  = in_data;
               end else begin
                  skip_s = 1'b0;
               end
`else
               skip_s = 1'b0;
`endif
               if (skip_s) begin
                  if (in_last) begin
                     state_d     = S_DONE;
                     sum_d       = acc_d;
                     sum_valid_d = 1'b1;
                  end else begin
                     state_d = S_FETCH;
                  end
               end else begin
                  // Operands are registered here so they are stable for the whole call.
                  state_d     = S_ISSUE;
                  add_start_d = 1'b1;
                  add_a_d     = acc_q;
               end
            end else begin
               state_d = S_FETCH;
            end
         end

         S_ISSUE: begin
            timer_d = TMR_W'(0);
            state_d = S_WAIT;
         end

         S_WAIT: begin
            if (add_finish) begin
               acc_d = add_result;
               if (last_f_q) begin
                  state_d     = S_DONE;
                  sum_d       = add_result;
                  sum_valid_d = 1'b1;
               end else begin
                  state_d = S_FETCH;
               end
            end else if (timer_q == TMR_LAST) begin
               // Adder hung: give back the accumulator untouched and flag it.
               timeout_err_d = 1'b1;
               state_d       = S_DONE;
               sum_d         = acc_q;
               sum_valid_d   = 1'b1;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end

         S_DONE: begin
            if (sum_ready) begin
               sum_valid_d = 1'b0;
               state_d     = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end

         default: begin
            state_d     = S_IDLE;
            sum_valid_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset aborts any operation immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         acc_q         <= 32'h0000_0000;
         opnd_q        <= 32'h0000_0000;
         last_f_q      <= 1'b0;
         timer_q       <= TMR_W'(0);
         count_q       <= CNT_W'(0);
         timeout_err_q <= 1'b0;
         add_start_q   <= 1'b0;
         add_a_q       <= 32'h0000_0000;
         sum_q         <= 32'h0000_0000;
         sum_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         opnd_q        <= opnd_d;
         last_f_q      <= last_f_d;
         timer_q       <= timer_d;
         count_q       <= count_d;
         timeout_err_q <= timeout_err_d;
         add_start_q   <= add_start_d;
         add_a_q       <= add_a_d;
         sum_q         <= sum_d;
         sum_valid_q   <= sum_valid_d;
      end
   end

   assign in_ready    = in_ready_s;
   assign add_a       = add_a_q;
   assign add_b       = opnd_q;
   assign add_start   = add_start_q;
   assign sum         = sum_q;
   assign sum_valid   = sum_valid_q;
   assign count       = count_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fp_accum_ctrl
//   Directed and randomized bench for fp_accum_ctrl.
//
//   Operand values are exact multiples of 1/16, so a plain integer model can
//   stand in for the FP adder and for the expected sums.
//
//   The adder peer keeps finish high, with a poisoned result, through the
//   cycle in which the next start is issued. This models a stale finish that
//   the controller must ignore.
// ----------------------------------------------------------------------------
module tb_fp_accum_ctrl;
   localparam int CNT_W = 16;
   localparam int TMO   = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [31:0]      in_data;
   logic             in_valid;
   logic             in_last;
   logic             in_ready;
   logic [31:0]      add_a;
   logic [31:0]      add_b;
   logic             add_start;
   logic [31:0]      add_result = 32'h0;
   logic             add_finish = 1'b0;
   logic [31:0]      sum;
   logic             sum_valid;
   logic             sum_ready;
   logic [CNT_W-1:0] count;
   logic             timeout_err;

   fp_accum_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .add_a(add_a), .add_b(add_b), .add_start(add_start),
      .add_result(add_result), .add_finish(add_finish),
      .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready),
      .count(count), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // adder peer controls (written by the stimulus only)
   int   lat = 4;
   logic hang = 1'b0;
   logic model_clr = 1'b0;

   // monitor / adder peer state
   int          cyc = 0, start_cyc = 0, sv_cyc = 0;
   int          pulse_viol = 0, stab_viol = 0, coexist_viol = 0;
   logic        start_prev = 1'b0, sv_prev = 1'b0;
   logic [31:0] obs_a[$];
   logic [31:0] obs_b[$];
   logic [31:0] op_a = 32'h0, op_b = 32'h0;
   int          cnt = 0;
   logic        busy = 1'b0;

   int stim[$];
   int last_base = 0;

   // value = v/16 encoded as IEEE single (exact for the small values used here)
   function automatic logic [31:0] fx2f(input int v);
      logic [31:0] r;
      int m;
      int p;
      if (v == 0) return 32'h0;
      m = (v < 0) ? -v : v;
      p = 0;
      for (int i = 0; i < 31; i++) if (m[i]) p = i;
      r = 32'h0;
      r[31] = (v < 0);
      r[30:23] = 8'(123 + p);
      r[22:0] = 23'(m << (23 - p));
      return r;
   endfunction

   function automatic int f2fx(input logic [31:0] f);
      int e;
      int m;
      int sh;
      int v;
      if (f[30:0] == 31'd0) return 0;
      e  = int'(f[30:23]);
      m  = int'({1'b1, f[22:0]});
      sh = e - 127 + 4 - 23;
      if (sh >= 0) v = m <<< sh;
      else v = m >>> (-sh);
      return f[31] ? -v : v;
   endfunction

   // Protocol monitor plus behavioural FP adder peer.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (add_start) begin
         obs_a.push_back(add_a);
         obs_b.push_back(add_b);
         start_cyc <= cyc;
         if (start_prev) pulse_viol <= pulse_viol + 1;
      end
      start_prev <= add_start;
      if (sum_valid && !sv_prev) sv_cyc <= cyc;
      sv_prev <= sum_valid;
      if (sum_valid && in_ready) coexist_viol <= coexist_viol + 1;

      if (model_clr) begin
         busy       <= 1'b0;
         add_finish <= 1'b0;
         add_result <= 32'h0;
      end else if (add_start) begin
         op_a       <= add_a;
         op_b       <= add_b;
         cnt        <= lat;
         busy       <= 1'b1;
         add_result <= 32'h7FC0_1234;
      end else if (busy) begin
         if (add_a !== op_a || add_b !== op_b) stab_viol <= stab_viol + 1;
         add_finish <= 1'b0;
         if (cnt > 1) begin
            cnt <= cnt - 1;
         end else if (!hang) begin
            add_result <= fx2f(f2fx(op_a) + f2fx(op_b));
            add_finish <= 1'b1;
            busy       <= 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d, input logic last);
      int k;
      k = 0;
      in_data  = d;
      in_last  = last;
      in_valid = 1'b1;
      while (!in_ready && k < 100) begin
         tick();
         k++;
      end
      if (!in_ready) begin
         chk("push_ready_timeout", {31'd0, in_ready}, 32'd1);
      end else begin
         @(posedge clk);
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_sum(input string tag);
      int k;
      k = 0;
      while (!sum_valid && k < 400) begin
         tick();
         k++;
      end
      chk(tag, {31'd0, sum_valid}, 32'd1);
   endtask

   task automatic handshake();
      sum_ready = 1'b1;
      @(posedge clk);
      tick();
      sum_ready = 1'b0;
   endtask

   // Drive stim[] as one sum and compare against the arithmetic model.
   task automatic run_stream(input int lat_i, input int bp, input string tag);
      int acc;
      int base;
      int e;
      logic [31:0] ea[$];
      logic [31:0] eb[$];
      lat = lat_i;
      base = obs_a.size();
      last_base = base;
      acc = stim[0];
      for (int i = 1; i < stim.size(); i++) begin
         e = stim[i];
`ifdef FP_ACCUM_ZERO_SKIP_EN
         if (e == 0) continue;
         if (acc == 0) begin
            acc = e;
            continue;
         end
`endif
         ea.push_back(fx2f(acc));
         eb.push_back(fx2f(e));
         acc = acc + e;
      end
      for (int i = 0; i < stim.size(); i++) push(fx2f(stim[i]), (i == stim.size() - 1));
      wait_sum({tag, "_valid"});
      for (int k = 0; k < bp; k++) begin
         sum_ready = 1'b0;
         tick();
         chk({tag, "_bp_valid"}, {31'd0, sum_valid}, 32'd1);
         chk({tag, "_bp_sum"}, sum, fx2f(acc));
         chk({tag, "_bp_in_ready"}, {31'd0, in_ready}, 32'd0);
      end
      chk({tag, "_sum"}, sum, fx2f(acc));
      chk({tag, "_count"}, {16'd0, count}, 32'(stim.size()));
      chk({tag, "_tmo"}, {31'd0, timeout_err}, 32'd0);
      chk({tag, "_nstarts"}, 32'(obs_a.size() - base), 32'(ea.size()));
      for (int i = 0; i < ea.size() && base + i < obs_a.size(); i++) begin
         chk({tag, "_add_a"}, obs_a[base+i], ea[i]);
         chk({tag, "_add_b"}, obs_b[base+i], eb[i]);
      end
      handshake();
      chk({tag, "_valid_clr"}, {31'd0, sum_valid}, 32'd0);
      chk({tag, "_sum_kept"}, sum, fx2f(acc));
      chk({tag, "_count_kept"}, {16'd0, count}, 32'(stim.size()));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;
      rst = 1'b0; in_data = 32'h0; in_valid = 1'b0; in_last = 1'b0; sum_ready = 1'b0;
      model_clr = 1'b1;
      tick(); tick();
      // reset state
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_add_start", {31'd0, add_start}, 32'd0);
      chk("rst_add_a", add_a, 32'h0);
      chk("rst_add_b", add_b, 32'h0);
      chk("rst_sum", sum, 32'h0);
      chk("rst_sum_valid", {31'd0, sum_valid}, 32'd0);
      chk("rst_count", {16'd0, count}, 32'd0);
      chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
      rst = 1'b1;
      tick();
      model_clr = 1'b0;

      // single element: sum valid the cycle after the transfer, no adder call
      base = obs_a.size();
      push(32'h3F80_0000, 1'b1);
      chk("t1_valid", {31'd0, sum_valid}, 32'd1);
      chk("t1_sum", sum, 32'h3F80_0000);
      chk("t1_count", {16'd0, count}, 32'd1);
      chk("t1_in_ready", {31'd0, in_ready}, 32'd0);
      handshake();
      chk("t1_nstarts", 32'(obs_a.size() - base), 32'd0);

      // three-element stream, L=8, with backpressure
      stim = '{16, 32, 8};
      run_stream(8, 5, "t2");
      chk("t2_sum_const", sum, 32'h4060_0000);
      chk("t2_a0", obs_a[last_base], 32'h3F80_0000);
      chk("t2_b0", obs_b[last_base], 32'h4000_0000);
      chk("t2_a1", obs_a[last_base+1], 32'h4040_0000);
      chk("t2_b1", obs_b[last_base+1], 32'h3F00_0000);

      // adder timeout on the second element
      hang = 1'b1;
      lat = 2;
      push(32'h3F80_0000, 1'b0);
      push(32'h4000_0000, 1'b1);
      wait_sum("t4_valid");
      tick();
      chk("t4_tmo", {31'd0, timeout_err}, 32'd1);
      chk("t4_sum", sum, 32'h3F80_0000);
      chk("t4_count", {16'd0, count}, 32'd2);
      chk("t4_wait_cycles", 32'(sv_cyc - start_cyc), 32'(TMO + 1));
      handshake();
      chk("t4_tmo_sticky", {31'd0, timeout_err}, 32'd1);
      hang = 1'b0;
      push(32'h4000_0000, 1'b1);
      chk("t4_tmo_clr", {31'd0, timeout_err}, 32'd0);
      chk("t4_sum2", sum, 32'h4000_0000);
      handshake();

      // asynchronous reset while the adder call is being issued
      hang = 1'b1;
      push(32'h3F80_0000, 1'b0);
      push(32'h4000_0000, 1'b0);
      n = 0;
      while (!add_start && n < 20) begin
         tick();
         n++;
      end
      chk("t5_issue_seen", {31'd0, add_start}, 32'd1);
      #1 rst = 1'b0;
      model_clr = 1'b1;
      #1;
      chk("t5_add_start", {31'd0, add_start}, 32'd0);
      chk("t5_sum_valid", {31'd0, sum_valid}, 32'd0);
      chk("t5_count", {16'd0, count}, 32'd0);
      chk("t5_add_a", add_a, 32'h0);
      tick(); tick();
      rst = 1'b1;
      tick();
      model_clr = 1'b0;
      hang = 1'b0;
      chk("t5_in_ready", {31'd0, in_ready}, 32'd1);

      // zero operand in the middle of a stream
      base = obs_a.size();
      stim = '{32, 0, 16};
      run_stream(4, 0, "t6");
      chk("t6_sum_const", sum, 32'h4040_0000);
`ifdef FP_ACCUM_ZERO_SKIP_EN
      chk("t6_nstarts_const", 32'(obs_a.size() - base), 32'd1);
`else
      chk("t6_nstarts_const", 32'(obs_a.size() - base), 32'd2);
`endif

      // zero first element followed by nonzero operands
      stim = '{0, 24, -8};
      run_stream(3, 1, "t7");

      // randomized streams
      for (int s = 0; s < 14; s++) begin
         stim.delete();
         n = int'($urandom_range(1, 6));
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) stim.push_back(0);
            else stim.push_back(int'($urandom_range(0, 128)) - 64);
         end
         run_stream(int'($urandom_range(2, 6)), int'($urandom_range(0, 3)), "rnd");
      end

      chk("mon_pulse_width", 32'(pulse_viol), 32'd0);
      chk("mon_operand_stable", 32'(stab_viol), 32'd0);
      chk("mon_valid_ready_excl", 32'(coexist_viol), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
